// File: rtl/fir_coeff_pkg.sv
// Shared types for the FIR coefficient loader: coefficient words, tap banks and FSM states.
// Optional readback is enabled by defining FIR_COEFF_READBACK_EN.
package fir_coeff_pkg;

    localparam int NTAPS      = 4;
    localparam int COEFF_BITS = 18;

    typedef logic signed [COEFF_BITS-1:0] coeff_t;
    typedef coeff_t [NTAPS-1:0]            coeff_bank_t;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        FLUSH
    } state_t;

endpackage

// File: rtl/fir_coeff_loader_if.sv
// Bus bundle between a coefficient source and fir_coeff_loader.
// Readback signals exist only when FIR_COEFF_READBACK_EN is defined.
interface fir_coeff_loader_if;
    import fir_coeff_pkg::*;

    logic       wr_i;
    logic [1:0] wr_addr_i;
    coeff_t     wr_data_i;
    logic       commit_i;
    logic       abort_i;
    logic       sync_i;
    coeff_t     coeff0_o;
    coeff_t     coeff1_o;
    coeff_t     coeff2_o;
    coeff_t     coeff3_o;
    logic       busy_o;
    logic       update_o;
    logic       flush_o;
    logic       wr_err_o;
`ifdef FIR_COEFF_READBACK_EN
    logic       rd_sel_i;
    logic [1:0] rd_addr_i;
    coeff_t     rd_data_o;

    modport master (
        output wr_i, wr_addr_i, wr_data_i, commit_i, abort_i, sync_i, rd_sel_i, rd_addr_i,
        input  coeff0_o, coeff1_o, coeff2_o, coeff3_o, busy_o, update_o, flush_o, wr_err_o,
               rd_data_o
    );

    modport slave (
        input  wr_i, wr_addr_i, wr_data_i, commit_i, abort_i, sync_i, rd_sel_i, rd_addr_i,
        output coeff0_o, coeff1_o, coeff2_o, coeff3_o, busy_o, update_o, flush_o, wr_err_o,
               rd_data_o
    );
`else
    modport master (
        output wr_i, wr_addr_i, wr_data_i, commit_i, abort_i, sync_i,
        input  coeff0_o, coeff1_o, coeff2_o, coeff3_o, busy_o, update_o, flush_o, wr_err_o
    );

    modport slave (
        input  wr_i, wr_addr_i, wr_data_i, commit_i, abort_i, sync_i,
        output coeff0_o, coeff1_o, coeff2_o, coeff3_o, busy_o, update_o, flush_o, wr_err_o
    );
`endif

endinterface

// File: rtl/fir_coeff_loader.sv
// Shadow/active coefficient loader for the four-tap pre-add FIR; applies on a frame strobe, then flags a flush window.
// Define FIR_COEFF_READBACK_EN to add a registered shadow/active readback port.
module fir_coeff_loader
    import fir_coeff_pkg::*;
#(
    parameter int FLUSH_CYCLES = 8
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    fir_coeff_loader_if.slave  bus
);

    localparam int CNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             apply;

    coeff_bank_t      shadow_q;
    coeff_bank_t      active_q;
    logic             busy_q;
    logic             update_q;
    logic             flush_q;
    logic             wr_err_q;

    // Abort wins over sync in ARMED; the counter holds the flush cycles still to come.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        apply   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.commit_i) state_d = ARMED;
            end
            ARMED: begin
                if (bus.abort_i) begin
                    state_d = IDLE;
                end else if (bus.sync_i) begin
                    apply = 1'b1;
                    if (FLUSH_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = FLUSH;
                        cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                    end
                end
            end
            FLUSH: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            busy_q   <= 1'b0;
            update_q <= 1'b0;
            flush_q  <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= (state_d != IDLE);
            update_q <= apply;
            flush_q  <= (state_d == FLUSH);
            wr_err_q <= bus.wr_i && (state_q != IDLE);
            if (bus.wr_i && (state_q == IDLE)) shadow_q[bus.wr_addr_i] <= bus.wr_data_i;
            if (apply) active_q <= shadow_q;
        end
    end

`ifdef FIR_COEFF_READBACK_EN
    coeff_t rd_data_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)          rd_data_q <= '0;
        else if (bus.rd_sel_i) rd_data_q <= active_q[bus.rd_addr_i];
        else                   rd_data_q <= shadow_q[bus.rd_addr_i];
    end

    assign bus.rd_data_o = rd_data_q;
`endif

    assign bus.coeff0_o = active_q[0];
    assign bus.coeff1_o = active_q[1];
    assign bus.coeff2_o = active_q[2];
    assign bus.coeff3_o = active_q[3];
    assign bus.busy_o   = busy_q;
    assign bus.update_o = update_q;
    assign bus.flush_o  = flush_q;
    assign bus.wr_err_o = wr_err_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed self-checking bench for fir_coeff_loader: one DUT with an 8-cycle flush, one with none.
// Both DUTs share the same stimulus; readback inputs are tied off when FIR_COEFF_READBACK_EN is defined.
module tb_fir_coeff_loader;
    import fir_coeff_pkg::*;

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b0;
    int   errors  = 0;
    int   checks  = 0;

    fir_coeff_loader_if bus8 ();
    fir_coeff_loader_if bus0 ();

    fir_coeff_loader #(.FLUSH_CYCLES(8)) dut8 (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus8.slave)
    );

    fir_coeff_loader #(.FLUSH_CYCLES(0)) dut0 (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus0.slave)
    );

    always #5 clk_i = ~clk_i;

    task automatic driveInputs(input logic wr, input logic [1:0] addr, input coeff_t data,
                               input logic commit, input logic abort, input logic sync);
        bus8.wr_i = wr;  bus8.wr_addr_i = addr; bus8.wr_data_i = data;
        bus8.commit_i = commit; bus8.abort_i = abort; bus8.sync_i = sync;
        bus0.wr_i = wr;  bus0.wr_addr_i = addr; bus0.wr_data_i = data;
        bus0.commit_i = commit; bus0.abort_i = abort; bus0.sync_i = sync;
    endtask

    // One clock cycle with the given inputs; returns 1 time unit after the edge with inputs idle again.
    task automatic applyStimulus(input logic wr, input logic [1:0] addr, input coeff_t data,
                                 input logic commit, input logic abort, input logic sync);
        driveInputs(wr, addr, data, commit, abort, sync);
        @(posedge clk_i);
        #1;
        driveInputs(1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic writeTap(input logic [1:0] addr, input coeff_t data);
        applyStimulus(1'b1, addr, data, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        driveInputs(1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0);
`ifdef FIR_COEFF_READBACK_EN
        bus8.rd_sel_i = 1'b0; bus8.rd_addr_i = 2'd0;
        bus0.rd_sel_i = 1'b0; bus0.rd_addr_i = 2'd0;
`endif
        $display("[TB] start");

        // Power-on reset
        rst_n_i = 1'b0;
        idleCycles(2);
        rst_n_i = 1'b1;
        checkOutput("rst_coeff0", bus8.coeff0_o, 0);
        checkOutput("rst_coeff1", bus8.coeff1_o, 0);
        checkOutput("rst_coeff2", bus8.coeff2_o, 0);
        checkOutput("rst_coeff3", bus8.coeff3_o, 0);
        checkOutput("rst_busy",   bus8.busy_o,   0);
        checkOutput("rst_flush",  bus8.flush_o,  0);
        checkOutput("rst_update", bus8.update_o, 0);
        checkOutput("rst_wr_err", bus8.wr_err_o, 0);

        // Apply a bank, then reset in the middle of its flush window
        writeTap(2'd0, 18'sd100);
        writeTap(2'd1, 18'sd200);
        writeTap(2'd2, -18'sd300);
        writeTap(2'd3, 18'sd400);
        applyStimulus(1'b0, 2'd0, '0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("pre_rst_coeff2", bus8.coeff2_o, -300);
        checkOutput("pre_rst_flush",  bus8.flush_o,  1);
        idleCycles(2);
        rst_n_i = 1'b0;
        idleCycles(1);
        rst_n_i = 1'b1;
        checkOutput("mid_rst_coeff0", bus8.coeff0_o, 0);
        checkOutput("mid_rst_coeff1", bus8.coeff1_o, 0);
        checkOutput("mid_rst_coeff2", bus8.coeff2_o, 0);
        checkOutput("mid_rst_coeff3", bus8.coeff3_o, 0);
        checkOutput("mid_rst_busy",   bus8.busy_o,   0);
        checkOutput("mid_rst_flush",  bus8.flush_o,  0);

        // Normal apply: values held while ARMED, visible right after the sync edge
        writeTap(2'd0, 18'sd1);
        writeTap(2'd1, 18'sd2);
        writeTap(2'd2, 18'sd3);
        writeTap(2'd3, -18'sd4);
        applyStimulus(1'b0, 2'd0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("armed_busy", bus8.busy_o, 1);
        idleCycles(3);
        checkOutput("armed_coeff0_held", bus8.coeff0_o, 0);
        checkOutput("armed_coeff3_held", bus8.coeff3_o, 0);
        checkOutput("armed_no_update",   bus8.update_o, 0);
        checkOutput("armed_no_flush",    bus8.flush_o,  0);
        applyStimulus(1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("apply_coeff0", bus8.coeff0_o, 1);
        checkOutput("apply_coeff1", bus8.coeff1_o, 2);
        checkOutput("apply_coeff2", bus8.coeff2_o, 3);
        checkOutput("apply_coeff3", bus8.coeff3_o, -4);
        checkOutput("apply_update", bus8.update_o, 1);
        checkOutput("apply_flush",  bus8.flush_o,  1);
        checkOutput("apply_busy",   bus8.busy_o,   1);
        checkOutput("nf_update",    bus0.update_o, 1);
        checkOutput("nf_flush",     bus0.flush_o,  0);
        checkOutput("nf_busy",      bus0.busy_o,   0);
        checkOutput("nf_coeff3",    bus0.coeff3_o, -4);

        // Dropped write during FLUSH (second flush cycle)
        writeTap(2'd2, 18'sd999);
        checkOutput("drop_wr_err",    bus8.wr_err_o, 1);
        checkOutput("drop_update",    bus8.update_o, 0);
        checkOutput("drop_flush",     bus8.flush_o,  1);
        checkOutput("nf_update_next", bus0.update_o, 0);
        checkOutput("nf_flush_next",  bus0.flush_o,  0);
        for (int i = 0; i < 6; i++) begin
            idleCycles(1);
            checkOutput($sformatf("flush_hold_%0d", i + 3), bus8.flush_o, 1);
        end
        checkOutput("wr_err_single", bus8.wr_err_o, 0);
        idleCycles(1);
        checkOutput("flush_end",       bus8.flush_o,  0);
        checkOutput("flush_end_busy",  bus8.busy_o,   0);
        checkOutput("flush_end_coeff", bus8.coeff1_o, 2);

        // Recommit without writes: shadow tap 2 kept its old value
        applyStimulus(1'b0, 2'd0, '0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("reapply_coeff2", bus8.coeff2_o, 3);
        checkOutput("reapply_update", bus8.update_o, 1);
        idleCycles(8);
        checkOutput("reapply_idle", bus8.busy_o, 0);

        // Abort and sync together in ARMED: abort wins
        writeTap(2'd0, 18'sd55);
        applyStimulus(1'b0, 2'd0, '0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b1);
        checkOutput("abort_busy",   bus8.busy_o,   0);
        checkOutput("abort_update", bus8.update_o, 0);
        checkOutput("abort_flush",  bus8.flush_o,  0);
        checkOutput("abort_coeff0", bus8.coeff0_o, 1);
        applyStimulus(1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("idle_sync_update", bus8.update_o, 0);
        checkOutput("idle_sync_busy",   bus8.busy_o,   0);

        // Write + commit + sync in one IDLE cycle: write included, sync ignored
        applyStimulus(1'b1, 2'd3, 18'sd77, 1'b1, 1'b0, 1'b1);
        checkOutput("wc_busy",   bus8.busy_o,   1);
        checkOutput("wc_update", bus8.update_o, 0);
        checkOutput("wc_coeff3", bus8.coeff3_o, -4);
        applyStimulus(1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("wc_apply_coeff3", bus8.coeff3_o, 77);
        checkOutput("wc_apply_coeff0", bus8.coeff0_o, 55);
        checkOutput("wc_apply_update", bus8.update_o, 1);
        idleCycles(8);
        checkOutput("final_busy",  bus8.busy_o,  0);
        checkOutput("final_flush", bus8.flush_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_coeff_loader.md
Name: fir_coeff_loader

Overview:
- Upstream coefficient stage for the four-tap systolic pre-add FIR.
- Accepts serial coefficient writes into a shadow bank.
- On a commit request, transfers the shadow bank to the active coefficient outputs atomically, on the next sample-frame strobe.
- After the transfer, flags a flush window while old products drain through the DSP cascade.

Parameters:
- NTAPS, 4, number of coefficient outputs (fixed to 4 for this filter).
- COEFF_BITS, 18, coefficient width (DSP B-port width).
- FLUSH_CYCLES, 8, cycles flush_o stays high after an apply; 0 allowed.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  synchronous active-low reset
- wr_i  in  1  shadow write strobe
- wr_addr_i  in  2  shadow tap index 0..3
- wr_data_i  in  COEFF_BITS  signed coefficient
- commit_i  in  1  request transfer shadow->active
- abort_i  in  1  cancel a pending commit
- sync_i  in  1  sample-frame strobe; transfer happens only here
- coeff0_o..coeff3_o  out  COEFF_BITS each  active coefficients to DSP B ports
- busy_o  out  1  state != IDLE
- update_o  out  1  one-cycle pulse, first cycle new coefficients are visible
- flush_o  out  1  high during the flush window
- wr_err_o  out  1  one-cycle pulse, write dropped

Behaviour:
- Reset (rst_n_i low at an edge): state IDLE, shadow and active banks all 0, all outputs 0. Reset overrides everything, including mid-ARMED or mid-FLUSH; no apply occurs.
- All outputs are registered.
- States:
  - IDLE: wr_i writes shadow[wr_addr_i] at the edge. commit_i -> ARMED. sync_i is ignored in IDLE, even in the same cycle as commit_i.
  - ARMED:
    - abort_i -> IDLE, no transfer; abort has priority over sync_i.
    - Otherwise, sync_i -> active <= shadow (all four taps in the same edge) and update_o=1 in the following cycle.
    - Then -> FLUSH with counter = FLUSH_CYCLES-1, or -> IDLE if FLUSH_CYCLES=0.
    - commit_i is ignored in this state.
  - FLUSH: flush_o=1 for exactly FLUSH_CYCLES cycles, starting the same cycle as update_o; then -> IDLE. commit_i and abort_i are ignored.
- Writes:
  - Accepted only in IDLE.
  - wr_i in ARMED or FLUSH: shadow unchanged, wr_err_o pulses 1 cycle later.
  - A write and commit_i in the same IDLE cycle: the write lands in shadow and is included in the commit.
- Latency: sync_i sampled at edge N -> new coeffN_o, update_o and flush_o valid after edge N.
- The active bank never changes except at an ARMED+sync_i edge or at reset.
- Shadow retains its contents after an apply; a second commit with no writes reapplies identical values.
- abort_i outside ARMED has no effect.

Optional Feature:
- Macro: FIR_COEFF_READBACK_EN.
- Defined:
  - Adds ports rd_sel_i (in, 1: 0=shadow, 1=active), rd_addr_i (in, 2) and rd_data_o (out, COEFF_BITS).
  - rd_data_o is registered, 1-cycle latency, reset 0, readable in any state.
- Not defined: these ports and their logic are absent.

Decomposition:
- Package fir_coeff_pkg holds:
  - COEFF_BITS = 18
  - coeff_t (signed logic [COEFF_BITS-1:0])
  - coeff_bank_t (coeff_t [3:0])
  - state enum {IDLE, ARMED, FLUSH}
- Single module; no sub-module. The flush counter is inline.

Test Plan:
- Reset: write taps 0..3 = 100, 200, -300, 400, commit, sync. Then assert rst_n_i low 1 cycle. Required: all coeffN_o = 0, busy_o = 0, flush_o = 0.
- Normal apply: write 1, 2, 3, -4, commit at cycle 10, sync at cycle 15. Required:
  - coeffN_o unchanged through cycle 15, new values from cycle 16.
  - update_o high only in cycle 16.
  - flush_o high cycles 16-23.
  - busy_o low from cycle 24.
- Dropped write: during FLUSH, write tap 2 = 999. Required: wr_err_o pulse next cycle; shadow tap 2 unchanged (recommit+sync shows the old value).
- Abort vs sync: ARMED with abort_i and sync_i high together. Required: IDLE, coefficients unchanged, no update_o.
- Same-cycle write+commit: write tap 3 = 77 with commit_i in IDLE, then sync. Required: coeff3_o = 77. Also, sync_i in the commit cycle is ignored; a later sync is needed.
- FLUSH_CYCLES=0 build: apply. Required: update_o pulse, flush_o never high, IDLE the cycle after apply.
